muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/div_step.sv | 19 +
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared func3 codes, state encoding and helpers for the RV32M sequencer
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int div_iters(input int steps);
        return 32 / steps;
    endfunction

    localparam int DIV_STEPS_DEFAULT = 1;
    localparam int DIV_ITERS = div_iters(DIV_STEPS_DEFAULT);

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-divide step (shift in next dividend bit, trial subtract)
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);
    logic [W:0] trial;
    logic [W:0] diff;

    // quo holds the not-yet-consumed dividend bits on the left, quotient bits fill from the right
    assign trial    = {rem, quo[W-1]};
    assign diff     = trial - {1'b0, divisor};
    assign rem_next = diff[W] ? trial[W-1:0] : diff[W-1:0];
    assign quo_next = {quo[W-2:0], ~diff[W]};
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multiply/divide sequencer with pipeline stall and done pulse
// Optional divide/remainder result reuse: define MULDIV_REM_FUSE_EN.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int ITERS = div_iters(DIV_STEPS);

    state_t            state;
    logic [1:0]        f3;
    logic [XLEN-1:0]   quo, rem, dvs;
    logic [5:0]        count;
    logic              neg_q, neg_r;

    logic              accept, sgn_in, div_zero, div_ovf, fuse_hit;
    logic [XLEN-1:0]   special_res, fuse_res, mul_res, q_fix, r_fix;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]   rem_c [0:DIV_STEPS];
    logic [XLEN-1:0]   quo_c [0:DIV_STEPS];

    assign accept   = start && (state == ST_IDLE) && !flush;
    assign sgn_in   = !func3[0];
    assign div_zero = (op2 == '0);
    assign div_ovf  = sgn_in && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign stall    = accept || (busy && !done);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = func3[1] ? op1 : '1;
        else
            special_res = func3[1] ? '0 : op1;
    end

    // 33x33 signed product, evaluated in 64 bits since only the low 64 bits are ever used
    assign ma      = {{XLEN{(f3 != 2'b11) & quo[XLEN-1]}}, quo};
    assign mb      = {{XLEN{!f3[1] & dvs[XLEN-1]}}, dvs};
    assign prod    = ma * mb;
    assign mul_res = (f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign q_fix = neg_q ? (~quo + 1'b1) : quo;
    assign r_fix = neg_r ? (~rem + 1'b1) : rem;

    assign rem_c[0] = rem;
    assign quo_c[0] = quo;
    for (genvar i = 0; i < DIV_STEPS; i++) begin : g_step
        div_step #(.W(XLEN)) u_step (
            .rem      (rem_c[i]),
            .quo      (quo_c[i]),
            .divisor  (dvs),
            .rem_next (rem_c[i+1]),
            .quo_next (quo_c[i+1])
        );
    end

`ifdef MULDIV_REM_FUSE_EN
    logic            fuse_valid, fuse_sgn;
    logic [XLEN-1:0] fuse_op1, fuse_op2, fuse_q, fuse_r;
    assign fuse_hit = fuse_valid && (fuse_op1 == op1) && (fuse_op2 == op2) && (fuse_sgn == sgn_in);
    assign fuse_res = func3[1] ? fuse_r : fuse_q;
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            f3     <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`ifdef MULDIV_REM_FUSE_EN
            fuse_valid <= 1'b0;
            fuse_sgn   <= 1'b0;
            fuse_op1   <= '0;
            fuse_op2   <= '0;
            fuse_q     <= '0;
            fuse_r     <= '0;
`endif
        end else if (flush && (state == ST_MUL || state == ST_DIV || state == ST_FIX)) begin
            // abort leaves result untouched and never pulses done
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MULDIV_REM_FUSE_EN
            fuse_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3   <= func3[1:0];
                        busy <= 1'b1;
                        if (func3[2] && (div_zero || div_ovf)) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (func3[2] && fuse_hit) begin
                            result <= fuse_res;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (func3[2]) begin
                            quo   <= mag(op1, sgn_in);
                            dvs   <= mag(op2, sgn_in);
                            rem   <= '0;
                            count <= 6'(ITERS);
                            neg_q <= sgn_in && (op1[XLEN-1] ^ op2[XLEN-1]);
                            neg_r <= sgn_in && op1[XLEN-1];
                            state <= ST_DIV;
`ifdef MULDIV_REM_FUSE_EN
                            fuse_valid <= 1'b0;
                            fuse_op1   <= op1;
                            fuse_op2   <= op2;
                            fuse_sgn   <= sgn_in;
`endif
                        end else begin
                            quo   <= op1;
                            dvs   <= op2;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    result <= mul_res;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DIV: begin
                    rem   <= rem_c[DIV_STEPS];
                    quo   <= quo_c[DIV_STEPS];
                    count <= count - 6'd1;
                    if (count == 6'd1)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= f3[1] ? r_fix : q_fix;
                    done   <= 1'b1;
                    state  <= ST_DONE;
`ifdef MULDIV_REM_FUSE_EN
                    fuse_valid <= 1'b1;
                    fuse_q     <= q_fix;
                    fuse_r     <= r_fix;
`endif
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
`ifdef MULDIV_REM_FUSE_EN
            if (flush)
                fuse_valid <= 1'b0;
`endif
        end
    end
endmodule
